// File: rtl/vedic_mul8_seq_pkg.sv
// Shared types and step tables for the sequential 8x8 vedic multiplier.
package vedic_mul8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned STEPS  = 4;
    localparam int unsigned STEP_W = 2;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PP_W   = 8;

    // Bit n set means step n takes the high nibble of that operand.
    localparam logic [STEPS-1:0] A_HI_MASK = 4'b1010;
    localparam logic [STEPS-1:0] B_HI_MASK = 4'b1100;

    // Partial-product shift per step.
    localparam int unsigned SHIFT_S0 = 0;
    localparam int unsigned SHIFT_S1 = 4;
    localparam int unsigned SHIFT_S2 = 4;
    localparam int unsigned SHIFT_S3 = 8;

    function automatic int unsigned step_shift(input logic [STEP_W-1:0] step);
        int unsigned sh;
        case (step)
            2'd0:    sh = SHIFT_S0;
            2'd1:    sh = SHIFT_S1;
            2'd2:    sh = SHIFT_S2;
            default: sh = SHIFT_S3;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/vedic_mul8_seq_vedic_4x4.sv
// Combinational 4x4 unsigned vedic (urdhva-tiryagbhyam) multiplier built from 2x2 blocks.
module vedic_4x4
    import vedic_mul8_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [PP_W-1:0]  prod_c
);

    // 2x2 vedic block: vertical and crosswise products with a single carry.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
        logic cross_a;
        logic cross_b;
        logic carry;
        logic high;
        cross_a = x[1] & y[0];
        cross_b = x[0] & y[1];
        carry   = cross_a & cross_b;
        high    = x[1] & y[1];
        return {high & carry, high ^ carry, cross_a ^ cross_b, x[0] & y[0]};
    endfunction

    logic [3:0] m_ll;
    logic [3:0] m_hl;
    logic [3:0] m_lh;
    logic [3:0] m_hh;

    // Four 2x2 sub-products combined with crosswise sum at shift 2 and high term at shift 4.
    always_comb begin
        m_ll   = vedic_2x2(a[1:0], b[1:0]);
        m_hl   = vedic_2x2(a[3:2], b[1:0]);
        m_lh   = vedic_2x2(a[1:0], b[3:2]);
        m_hh   = vedic_2x2(a[3:2], b[3:2]);
        prod_c = PP_W'(m_ll)
               + PP_W'((PP_W'(m_hl) + PP_W'(m_lh)) << 2)
               + PP_W'(PP_W'(m_hh) << 4);
    end

endmodule

// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 multiply / multiply-accumulate over one shared 4x4 vedic multiplier.
module vedic_mul8_seq
    import vedic_mul8_seq_pkg::*;
#(
    parameter int unsigned ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    state_t             state_q;
    state_t             state_d;
    logic [STEP_W-1:0]  step_q;
    logic [7:0]         a_q;
    logic [7:0]         b_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;

    logic               accept;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [PP_W-1:0]    pp;
    logic [ACC_W-1:0]   pp_shifted;
    logic [ACC_W:0]     sum;

    // Operand nibble selection and shifted accumulate for the current step.
    always_comb begin
        nib_a      = A_HI_MASK[step_q] ? a_q[7:4] : a_q[3:0];
        nib_b      = B_HI_MASK[step_q] ? b_q[7:4] : b_q[3:0];
        pp_shifted = ACC_W'(ACC_W'(pp) << step_shift(step_q));
        sum        = (ACC_W+1)'(acc_q) + (ACC_W+1)'(pp_shifted);
    end

    vedic_4x4 u_vedic_4x4 (
        .a      (nib_a),
        .b      (nib_b),
        .prod_c (pp)
    );

    assign accept = (state_q == IDLE) && in_valid;

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = MUL;
            MUL:  if (step_q == STEP_W'(STEPS - 1)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, step counter, accumulator and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q    <= in_a;
            b_q    <= in_b;
            step_q <= '0;
            if (!in_acc) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end
        end else if (state_q == MUL) begin
            acc_q  <= sum[ACC_W-1:0];
            step_q <= step_q + STEP_W'(1);
            if (sum[ACC_W]) ovf_q <= 1'b1;
        end
    end

    assign out_data = acc_q;
    assign out_ovf  = ovf_q;

endmodule
